// File: rtl/pipeline_perf_monitor_if.sv
// Hazard/control/PC taps from the CPU into the performance monitor, plus the
// monitor's registered statistics.
interface pipeline_perf_monitor_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic             clear_i;
    logic             stall_i;
    logic             branch_i;
    logic             flush_i;
    logic [31:0]      pc_i;
    logic [CNT_W-1:0] cycle_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [31:0]      last_pc_o;
    logic             busy_o;
    logic             halt_o;

    modport master (
        output start_i, clear_i, stall_i, branch_i, flush_i, pc_i,
        input  cycle_cnt_o, stall_cnt_o, flush_cnt_o, last_pc_o, busy_o, halt_o
    );

    modport slave (
        input  start_i, clear_i, stall_i, branch_i, flush_i, pc_i,
        output cycle_cnt_o, stall_cnt_o, flush_cnt_o, last_pc_o, busy_o, halt_o
    );
endinterface

// File: rtl/pipeline_perf_monitor.sv
// Counts run cycles, load-use stalls and branch flushes of the pipelined CPU and
// raises halt after MAX_CYCLES counted cycles (0 = run forever).
module pipeline_perf_monitor #(
    parameter int          CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 30
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    pipeline_perf_monitor_if.slave  mon
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [CNT_W-1:0] SAT     = '1;
    localparam logic [CNT_W-1:0] HALT_AT = CNT_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

    generate
        if (CNT_W < 8 || CNT_W > 32) begin : g_bad_width
            $error("CNT_W must be in 8..32");
        end
        if (64'(MAX_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_max
            $error("MAX_CYCLES must be below 2**CNT_W");
        end
    endgenerate

    state_t           state, state_nxt;
    logic             count_en;
    logic             busy, halt;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
    logic [31:0]      last_pc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == SAT) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (mon.clear_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (mon.start_i) state_nxt = RUN;
                PAUSE: if (mon.start_i) state_nxt = RUN;
                RUN: begin
                    if (!mon.start_i)
                        state_nxt = PAUSE;
                    // the edge that reaches MAX_CYCLES is still counted
                    else if (MAX_CYCLES != 0 && cycle_cnt == HALT_AT)
                        state_nxt = DONE;
                end
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state == RUN);
        halt     = (state == DONE);
        count_en = (state == RUN) && mon.start_i && !mon.clear_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || mon.clear_i) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            last_pc   <= '0;
        end else if (count_en) begin
            cycle_cnt <= sat_inc(cycle_cnt);
            // a stall raised under a branch is a branch bubble, not a load-use stall
            if (mon.stall_i && !mon.branch_i) stall_cnt <= sat_inc(stall_cnt);
            if (mon.flush_i)                  flush_cnt <= sat_inc(flush_cnt);
            last_pc <= mon.pc_i;
        end
    end

    assign mon.cycle_cnt_o = cycle_cnt;
    assign mon.stall_cnt_o = stall_cnt;
    assign mon.flush_cnt_o = flush_cnt;
    assign mon.last_pc_o   = last_pc;
    assign mon.busy_o      = busy;
    assign mon.halt_o      = halt;
endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Drives two monitors (32-bit/halt at 30 and 8-bit/unlimited) with the same
// stimulus and compares every output each cycle against a behavioural model.
module tb_pipeline_perf_monitor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_perf_monitor_if #(.CNT_W(32)) bus0 ();
    pipeline_perf_monitor_if #(.CNT_W(8))  bus1 ();

    pipeline_perf_monitor #(.CNT_W(32), .MAX_CYCLES(30)) dut0 (.clk_i(clk), .rst_i(rst), .mon(bus0));
    pipeline_perf_monitor #(.CNT_W(8),  .MAX_CYCLES(0))  dut1 (.clk_i(clk), .rst_i(rst), .mon(bus1));

    int vectors = 0;
    int errors  = 0;

    // reference model: one entry per monitor
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    longint unsigned m_cyc [2], m_stl [2], m_fls [2], m_pc [2];
    int              m_mode[2];
    longint unsigned m_max [2] = '{30, 0};
    longint unsigned m_top [2] = '{64'hFFFF_FFFF, 255};

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned bump(input longint unsigned v, input longint unsigned top);
        return (v < top) ? v + 1 : v;
    endfunction

    task automatic model_edge(input int d, input logic r, cl, st, sl, br, fl, input logic [31:0] pc);
        if (r || cl) begin
            m_cyc[d] = 0; m_stl[d] = 0; m_fls[d] = 0; m_pc[d] = 0; m_mode[d] = M_IDLE;
        end else if (m_mode[d] == M_IDLE || m_mode[d] == M_PAUSE) begin
            if (st) m_mode[d] = M_RUN;
        end else if (m_mode[d] == M_RUN) begin
            if (!st) m_mode[d] = M_PAUSE;
            else begin
                m_cyc[d] = bump(m_cyc[d], m_top[d]);
                if (sl && !br) m_stl[d] = bump(m_stl[d], m_top[d]);
                if (fl)        m_fls[d] = bump(m_fls[d], m_top[d]);
                m_pc[d] = pc;
                if (m_max[d] != 0 && m_cyc[d] == m_max[d]) m_mode[d] = M_DONE;
            end
        end
    endtask

    task automatic check_dut(input string n, input int d, input longint unsigned c, s, f,
                             input logic [31:0] pc, input logic b, h);
        chk({n, ".cycle"}, c, m_cyc[d]);
        chk({n, ".stall"}, s, m_stl[d]);
        chk({n, ".flush"}, f, m_fls[d]);
        chk({n, ".last_pc"}, pc, m_pc[d]);
        chk({n, ".busy"}, b, m_mode[d] == M_RUN);
        chk({n, ".halt"}, h, m_mode[d] == M_DONE);
    endtask

    // apply one set of inputs across one rising edge, then check both monitors
    task automatic step(input logic r, cl, st, sl, br, fl, input logic [31:0] pc);
        rst = r;
        bus0.clear_i = cl; bus0.start_i = st; bus0.stall_i = sl;
        bus0.branch_i = br; bus0.flush_i = fl; bus0.pc_i = pc;
        bus1.clear_i = cl; bus1.start_i = st; bus1.stall_i = sl;
        bus1.branch_i = br; bus1.flush_i = fl; bus1.pc_i = pc;
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d, r, cl, st, sl, br, fl, pc);
        @(negedge clk);
        check_dut("m32", 0, bus0.cycle_cnt_o, bus0.stall_cnt_o, bus0.flush_cnt_o,
                  bus0.last_pc_o, bus0.busy_o, bus0.halt_o);
        check_dut("m8", 1, bus1.cycle_cnt_o, bus1.stall_cnt_o, bus1.flush_cnt_o,
                  bus1.last_pc_o, bus1.busy_o, bus1.halt_o);
    endtask

    initial begin
        logic [31:0] pc;
        // reset
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("reset.cycle", bus0.cycle_cnt_o, 0);
        chk("reset.busy", bus0.busy_o, 0);

        // run to halt at 30, then hold for 10 cycles
        for (int i = 0; i < 31; i++) step(0, 0, 1, 0, 0, 0, 32'(4 * i));
        chk("halt.cycle", bus0.cycle_cnt_o, 30);
        chk("halt.halt", bus0.halt_o, 1);
        chk("halt.busy", bus0.busy_o, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 0, 1, 32'h100);
        chk("done.hold", bus0.cycle_cnt_o, 30);

        // clear in DONE
        step(0, 1, 1, 0, 0, 0, 0);
        chk("clear.cycle", bus0.cycle_cnt_o, 0);
        chk("clear.halt", bus0.halt_o, 0);

        // stall counting with a branch bubble excluded
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0, 32'h10);
        step(0, 0, 1, 1, 1, 0, 32'h14);
        chk("stall.three", bus0.stall_cnt_o, 3);
        step(0, 0, 1, 1, 0, 1, 32'h18);
        chk("both.stall", bus0.stall_cnt_o, 4);
        chk("both.flush", bus0.flush_cnt_o, 1);

        // pause after 10 counted cycles
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 32'h20);
        chk("pause.pre", bus0.cycle_cnt_o, 10);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 32'h24);
        chk("pause.cycle", bus0.cycle_cnt_o, 10);
        chk("pause.busy", bus0.busy_o, 0);
        step(0, 0, 1, 0, 0, 0, 32'h28);
        chk("resume.cycle", bus0.cycle_cnt_o, 10);
        step(0, 0, 1, 0, 0, 0, 32'h2C);
        chk("resume.next", bus0.cycle_cnt_o, 11);
        chk("lastpc", bus0.last_pc_o, 32'h2C);

        // reset and clear together mid-run discard the edge
        step(1, 1, 1, 1, 0, 1, 32'h30);
        chk("rstclr.pc", bus0.last_pc_o, 0);
        chk("rstclr.cycle", bus1.cycle_cnt_o, 0);

        // randomized
        for (int i = 0; i < 400; i++) begin
            pc = $urandom;
            step(($urandom_range(63) == 0), ($urandom_range(31) == 0), ($urandom_range(7) != 0),
                 1'($urandom), 1'($urandom), 1'($urandom), pc);
        end

        // saturation of the 8-bit monitor with no halt limit
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) step(0, 0, 1, 0, 0, 1, 32'(i));
        chk("sat.cycle", bus1.cycle_cnt_o, 255);
        chk("sat.flush", bus1.flush_cnt_o, 255);
        chk("sat.halt", bus1.halt_o, 0);
        chk("sat.busy", bus1.busy_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
